// File: rtl/viterbi_pkg.sv
// Shared state type and default geometry for the Viterbi link BER checker.
package viterbi_pkg;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam int DEF_MAX_LAT  = 63;
   localparam int DEF_WIN      = 32;
   localparam int DEF_SYNC_THR = 0;
   localparam int DEF_LOSS_THR = 8;
   localparam int DEF_CW       = 32;

endpackage

// File: rtl/viterbi_ref_history.sv
// Reference bit history (hist[0] newest) with a latency-selected read tap.
module viterbi_ref_history #(
   parameter  int MAX_LAT = 63,
   localparam int LW      = $clog2(MAX_LAT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          din,
   input  logic [LW-1:0] sel,
   output logic          dout
);

   logic [MAX_LAT:0] hist;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      hist <= '0;
      else if (push) hist <= {hist[MAX_LAT-1:0], din};
   end

   // Read is combinational so a same-cycle push still compares against the old contents.
   assign dout = hist[sel];

endmodule

// File: rtl/viterbi_ber_checker.sv
// BER checker: searches decoder latency against the reference stream, then counts bits and errors.
module viterbi_ber_checker
   import viterbi_pkg::*;
#(
   parameter  int MAX_LAT  = DEF_MAX_LAT,
   parameter  int WIN      = DEF_WIN,
   parameter  int SYNC_THR = DEF_SYNC_THR,
   parameter  int LOSS_THR = DEF_LOSS_THR,
   parameter  int CW       = DEF_CW,
   localparam int LW       = $clog2(MAX_LAT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          ref_valid_i,
   input  logic          ref_bit_i,
   input  logic          dec_valid_i,
   input  logic          dec_bit_i,
   output logic          locked_o,
   output logic [LW-1:0] latency_o,
   output logic [CW-1:0] bit_ct_o,
   output logic [CW-1:0] err_ct_o,
   output logic          err_pulse_o,
   output logic          sat_o
);

   localparam int WW = $clog2(WIN);
   localparam int EW = $clog2(WIN + 1);

   localparam logic [WW-1:0] WIN_LAST = WW'(WIN - 1);
   localparam logic [EW-1:0] SYNC_T   = EW'(SYNC_THR);
   localparam logic [EW-1:0] LOSS_T   = EW'(LOSS_THR);
   localparam logic [LW-1:0] LAT_MAX  = LW'(MAX_LAT);

   state_e        state;
   logic [WW-1:0] win_ct;
   logic [EW-1:0] win_err;
   logic          hist_bit;
   logic          mis;
   logic          last;
   logic [EW-1:0] err_n;
   logic [CW-1:0] bit_nx;
   logic [CW-1:0] err_nx;

   viterbi_ref_history #(.MAX_LAT(MAX_LAT)) u_hist (
      .clk  (clk),
      .rst  (rst),
      .push (ref_valid_i),
      .din  (ref_bit_i),
      .sel  (latency_o),
      .dout (hist_bit)
   );

   assign mis    = dec_bit_i ^ hist_bit;
   assign last   = (win_ct == WIN_LAST);
   assign err_n  = win_err + {{(EW-1){1'b0}}, mis};
   // Counters stick at all-ones instead of wrapping.
   assign bit_nx = (&bit_ct_o) ? bit_ct_o : bit_ct_o + 1'b1;
   assign err_nx = (&err_ct_o) ? err_ct_o : err_ct_o + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= SEARCH;
         locked_o    <= 1'b0;
         latency_o   <= '0;
         win_ct      <= '0;
         win_err     <= '0;
         bit_ct_o    <= '0;
         err_ct_o    <= '0;
         err_pulse_o <= 1'b0;
         sat_o       <= 1'b0;
      end else begin
         err_pulse_o <= 1'b0;
         if (clr_i) begin
            state     <= SEARCH;
            locked_o  <= 1'b0;
            latency_o <= '0;
            win_ct    <= '0;
            win_err   <= '0;
            bit_ct_o  <= '0;
            err_ct_o  <= '0;
            sat_o     <= 1'b0;
         end else if (dec_valid_i) begin
            if (last) begin
               win_ct  <= '0;
               win_err <= '0;
            end else begin
               win_ct  <= win_ct + 1'b1;
               win_err <= err_n;
            end
            unique case (state)
               SEARCH: begin
                  if (last) begin
                     if (err_n <= SYNC_T) begin
                        state    <= LOCKED;
                        locked_o <= 1'b1;
                     end else begin
                        latency_o <= (latency_o == LAT_MAX) ? '0 : latency_o + 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  bit_ct_o <= bit_nx;
                  if (mis) begin
                     err_ct_o    <= err_nx;
                     err_pulse_o <= 1'b1;
                  end
                  sat_o <= sat_o | (&bit_nx) | (mis & (&err_nx));
                  // Lock is dropped only on the window's closing sample; counters are held.
                  if (last && (err_n > LOSS_T)) begin
                     state     <= SEARCH;
                     locked_o  <= 1'b0;
                     latency_o <= '0;
                  end
               end
               default: begin
                  state    <= SEARCH;
                  locked_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench for viterbi_ber_checker: lock, error count, loss, wrap, saturation, reset and stall.
module tb_viterbi_ber_checker;

   logic clk = 1'b0;
   logic rst, clr_i, ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i;

   logic        locked, err_pulse, sat;
   logic [5:0]  latency;
   logic [31:0] bit_ct, err_ct;

   logic        locked2, err_pulse2, sat2;
   logic [5:0]  latency2;
   logic [3:0]  bit_ct2, err_ct2;

   int checks   = 0;
   int failures = 0;
   int k        = 0;
   int lat      = 10;
   int pulses   = 0;
   logic prbs [127];

   always #5 clk = ~clk;

   viterbi_ber_checker dut (
      .clk(clk), .rst(rst), .clr_i(clr_i),
      .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
      .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
      .locked_o(locked), .latency_o(latency), .bit_ct_o(bit_ct),
      .err_ct_o(err_ct), .err_pulse_o(err_pulse), .sat_o(sat)
   );

   viterbi_ber_checker #(.CW(4), .LOSS_THR(32)) dut2 (
      .clk(clk), .rst(rst), .clr_i(clr_i),
      .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
      .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
      .locked_o(locked2), .latency_o(latency2), .bit_ct_o(bit_ct2),
      .err_ct_o(err_ct2), .err_pulse_o(err_pulse2), .sat_o(sat2)
   );

   function automatic logic ref_at(input int n);
      return (n < 0) ? 1'b0 : prbs[n % 127];
   endfunction

   // One sample with both valids; dec is the ref stream delayed per lat, optionally inverted.
   task automatic step(input logic inv);
      ref_valid_i = 1'b1;
      ref_bit_i   = ref_at(k);
      dec_valid_i = 1'b1;
      dec_bit_i   = ref_at(k - lat - 1) ^ inv;
      @(posedge clk);
      #1;
      ref_valid_i = 1'b0;
      dec_valid_i = 1'b0;
      @(negedge clk);
      k++;
   endtask

   task automatic do_reset();
      rst = 1'b0; clr_i = 1'b0;
      ref_valid_i = 1'b0; ref_bit_i = 1'b0;
      dec_valid_i = 1'b0; dec_bit_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      k = 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; clr_i = 1'b0;
      ref_valid_i = 1'b0; ref_bit_i = 1'b0;
      dec_valid_i = 1'b0; dec_bit_i = 1'b0;
      #2;
      checks++; if (locked !== 1'b0)    begin failures++; $display("FAIL reset_locked got=%0b want=0", locked); end
      checks++; if (latency !== 6'd0)   begin failures++; $display("FAIL reset_latency got=%0d want=0", latency); end
      checks++; if (bit_ct !== 32'd0)   begin failures++; $display("FAIL reset_bit_ct got=%0d want=0", bit_ct); end
      checks++; if (err_ct !== 32'd0)   begin failures++; $display("FAIL reset_err_ct got=%0d want=0", err_ct); end
      checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err_pulse got=%0b want=0", err_pulse); end
      checks++; if (sat !== 1'b0)       begin failures++; $display("FAIL reset_sat got=%0b want=0", sat); end
      do_reset();
   endtask

   task automatic test_lock();
      lat = 10;
      repeat (351) step(1'b0);
      checks++; if (locked !== 1'b0)  begin failures++; $display("FAIL lock_early got=%0b want=0", locked); end
      checks++; if (latency !== 6'd10) begin failures++; $display("FAIL lock_cand got=%0d want=10", latency); end
      step(1'b0);
      checks++; if (locked !== 1'b1)  begin failures++; $display("FAIL lock_rise got=%0b want=1", locked); end
      checks++; if (latency !== 6'd10) begin failures++; $display("FAIL lock_latency got=%0d want=10", latency); end
      checks++; if (err_ct !== 32'd0) begin failures++; $display("FAIL lock_err_ct got=%0d want=0", err_ct); end
      checks++; if (bit_ct !== 32'd0) begin failures++; $display("FAIL lock_bit_ct got=%0d want=0", bit_ct); end
   endtask

   task automatic test_errors();
      pulses = 0;
      for (int i = 0; i < 256; i++) begin
         step((i % 8) == 7);
         if (err_pulse === 1'b1) pulses++;
      end
      checks++; if (err_ct !== 32'd32)  begin failures++; $display("FAIL errors_err_ct got=%0d want=32", err_ct); end
      checks++; if (bit_ct !== 32'd256) begin failures++; $display("FAIL errors_bit_ct got=%0d want=256", bit_ct); end
      checks++; if (locked !== 1'b1)    begin failures++; $display("FAIL errors_locked got=%0b want=1", locked); end
      checks++; if (pulses !== 32)      begin failures++; $display("FAIL errors_pulses got=%0d want=32", pulses); end
   endtask

   task automatic test_loss();
      repeat (31) step(1'b1);
      checks++; if (locked !== 1'b1)    begin failures++; $display("FAIL loss_early got=%0b want=1", locked); end
      step(1'b1);
      checks++; if (locked !== 1'b0)    begin failures++; $display("FAIL loss_fall got=%0b want=0", locked); end
      checks++; if (latency !== 6'd0)   begin failures++; $display("FAIL loss_cand got=%0d want=0", latency); end
      checks++; if (err_ct !== 32'd64)  begin failures++; $display("FAIL loss_err_ct got=%0d want=64", err_ct); end
      step(1'b1);
      checks++; if (err_ct !== 32'd64)  begin failures++; $display("FAIL loss_err_hold got=%0d want=64", err_ct); end
      checks++; if (bit_ct !== 32'd288) begin failures++; $display("FAIL loss_bit_hold got=%0d want=288", bit_ct); end
      checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL loss_no_pulse got=%0b want=0", err_pulse); end
   endtask

   task automatic test_wrap();
      do_reset();
      lat = 63;
      repeat (2047) step(1'b0);
      checks++; if (locked !== 1'b0)   begin failures++; $display("FAIL wrap_early got=%0b want=0", locked); end
      checks++; if (latency !== 6'd63) begin failures++; $display("FAIL wrap_cand got=%0d want=63", latency); end
      step(1'b0);
      checks++; if (locked !== 1'b1)   begin failures++; $display("FAIL wrap_lock got=%0b want=1", locked); end
      // Inverted stream: lose lock, then sweep all candidates without a match.
      repeat (32) step(1'b1);
      checks++; if (locked !== 1'b0)   begin failures++; $display("FAIL wrap_loss got=%0b want=0", locked); end
      repeat (63 * 32) step(1'b1);
      checks++; if (latency !== 6'd63) begin failures++; $display("FAIL wrap_top got=%0d want=63", latency); end
      repeat (32) step(1'b1);
      checks++; if (latency !== 6'd0)  begin failures++; $display("FAIL wrap_zero got=%0d want=0", latency); end
      checks++; if (locked !== 1'b0)   begin failures++; $display("FAIL wrap_nolock got=%0b want=0", locked); end
   endtask

   task automatic test_saturation();
      do_reset();
      lat = 10;
      repeat (352) step(1'b0);
      checks++; if (locked2 !== 1'b1)  begin failures++; $display("FAIL sat_lock got=%0b want=1", locked2); end
      repeat (14) step(1'b1);
      checks++; if (err_ct2 !== 4'd14) begin failures++; $display("FAIL sat_err14 got=%0d want=14", err_ct2); end
      checks++; if (sat2 !== 1'b0)     begin failures++; $display("FAIL sat_early got=%0b want=0", sat2); end
      step(1'b1);
      checks++; if (sat2 !== 1'b1)     begin failures++; $display("FAIL sat_set got=%0b want=1", sat2); end
      repeat (5) step(1'b1);
      checks++; if (err_ct2 !== 4'd15) begin failures++; $display("FAIL sat_err_hold got=%0d want=15", err_ct2); end
      checks++; if (bit_ct2 !== 4'd15) begin failures++; $display("FAIL sat_bit_hold got=%0d want=15", bit_ct2); end
      checks++; if (locked2 !== 1'b1)  begin failures++; $display("FAIL sat_still_locked got=%0b want=1", locked2); end
      // Clear coincides with a valid mismatching sample; clear must win.
      clr_i = 1'b1;
      step(1'b1);
      clr_i = 1'b0;
      checks++; if (err_ct2 !== 4'd0)  begin failures++; $display("FAIL clr_err got=%0d want=0", err_ct2); end
      checks++; if (bit_ct2 !== 4'd0)  begin failures++; $display("FAIL clr_bit got=%0d want=0", bit_ct2); end
      checks++; if (sat2 !== 1'b0)     begin failures++; $display("FAIL clr_sat got=%0b want=0", sat2); end
      checks++; if (locked2 !== 1'b0)  begin failures++; $display("FAIL clr_locked got=%0b want=0", locked2); end
      checks++; if (bit_ct !== 32'd0)  begin failures++; $display("FAIL clr_bit_main got=%0d want=0", bit_ct); end
      checks++; if (err_pulse !== 1'b0) begin failures++; $display("FAIL clr_pulse got=%0b want=0", err_pulse); end
   endtask

   task automatic test_stall_reset();
      do_reset();
      lat = 10;
      repeat (100) step(1'b0);
      repeat (5) @(negedge clk);
      repeat (251) step(1'b0);
      checks++; if (locked !== 1'b0)   begin failures++; $display("FAIL stall_early got=%0b want=0", locked); end
      step(1'b0);
      checks++; if (locked !== 1'b1)   begin failures++; $display("FAIL stall_lock got=%0b want=1", locked); end
      for (int i = 0; i < 10; i++) step(i == 3);
      checks++; if (bit_ct !== 32'd10) begin failures++; $display("FAIL pre_rst_bit got=%0d want=10", bit_ct); end
      checks++; if (err_ct !== 32'd1)  begin failures++; $display("FAIL pre_rst_err got=%0d want=1", err_ct); end
      #2 rst = 1'b0;
      #1;
      checks++; if (locked !== 1'b0)   begin failures++; $display("FAIL arst_locked got=%0b want=0", locked); end
      checks++; if (bit_ct !== 32'd0)  begin failures++; $display("FAIL arst_bit got=%0d want=0", bit_ct); end
      checks++; if (err_ct !== 32'd0)  begin failures++; $display("FAIL arst_err got=%0d want=0", err_ct); end
      checks++; if (latency !== 6'd0)  begin failures++; $display("FAIL arst_latency got=%0d want=0", latency); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [6:0] s;
      logic       b;
      s = 7'h7F;
      for (int i = 0; i < 127; i++) begin
         b       = s[6] ^ s[5];
         prbs[i] = b;
         s       = {s[5:0], b};
      end
      test_reset();
      test_lock();
      test_errors();
      test_loss();
      test_wrap();
      test_saturation();
      test_stall_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
